// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed wait states, held response out.
// Optional macro DMEM_BOUNDS_CHECK_EN turns out-of-range indices into error responses instead of wrapping.
module dmem_responder #(
  parameter int WORD        = 64,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] read_data,
  output logic            rsp_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [WORD-1:0]   wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [WORD-1:0]   read_data_q, read_data_d;

  logic [WORD-1:0]   mem [DEPTH];
  logic [WORD-4:0]   addr_index;
  logic              out_of_range;
  logic              req_bad;
  logic              commit;

  assign addr_index = req_addr[WORD-1:3];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = (addr_index >= (WORD-3)'(DEPTH));
`else
  logic unused_addr_hi;
  assign out_of_range   = 1'b0;
  assign unused_addr_hi = ^addr_index[WORD-4:IDX_W];
`endif

  assign req_bad = (req_addr[2:0] != 3'b000) || (mem_read == mem_write) || out_of_range;

  // Memory access happens on the single edge that moves WAIT -> RESP.
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
          idx_d   = addr_index[IDX_W-1:0];
          write_d = mem_write;
          err_d   = req_bad;
          wdata_d = req_wdata;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = err_q;
          read_data_d = (!err_q && !write_q) ? mem[idx_q] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      read_data_q <= read_data_d;
    end
  end

  // No reset here: contents survive reset, and reset forces IDLE so a pending store never commits.
  always_ff @(posedge clk) begin
    if (commit && write_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign read_data = read_data_q;

endmodule
